reg_access_sequencer: RTL

Front-end sequencer for the single-port `register_bank`: accepts one operand-fetch/writeback request per handshake and serialises it onto the bank's shared `addr`/`write` port. Each request carries an optional write (rd) and up to two reads (rs1, rs2). The block returns both operands on a valid/ready response channel. It sits directly upstream of `register_bank`, between decode/writeback and the bank.

---
 rtl/reg_access_seq_pkg.sv | 26 ++
 rtl/reg_access_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/reg_access_seq_pkg.sv
// Shared types for reg_access_sequencer: default widths, FSM state encoding, latched request.
// The request struct is sized by the package defaults; the sequencer is built at those widths.
package reg_access_seq_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ1,
        ST_READ2,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] rs1;
        logic [DEF_ADDR_W-1:0] rs2;
        logic [DEF_ADDR_W-1:0] rd;
        logic                  rs1_en;
        logic                  rs2_en;
        logic                  wr_en;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/reg_access_sequencer.sv
// Serialises one write + two reads per request onto a single-port register bank, then returns operands.
// REG_ACCESS_SEQ_ZERO_REG_EN: register 0 reads as zero and is never written or read on the bank port.
module reg_access_sequencer
    import reg_access_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic              req_rs1_en,
    input  logic              req_rs2_en,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_wr_en,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_op1,
    output logic [DATA_W-1:0] rsp_op2,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write,
    input  logic [DATA_W-1:0] rf_data_out
);

`ifdef REG_ACCESS_SEQ_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    state_e            state_q, state_d;
    req_t              req_q, req_d, req_in;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic              req_ready_c, rsp_valid_c, rf_write_c;
    logic [ADDR_W-1:0] rf_addr_c;
    logic [DATA_W-1:0] rf_data_in_c;

    function automatic logic access_live(logic en, logic [ADDR_W-1:0] a);
        return en && !(ZERO_REG && (a == '0));
    endfunction

    // First access still to be issued after 'cur', in the fixed order WRITE, READ1, READ2.
    function automatic state_e next_access(req_t r, state_e cur);
        logic wr_ok, r1_ok, r2_ok;
        wr_ok = (cur == ST_IDLE) && access_live(r.wr_en, r.rd);
        r1_ok = ((cur == ST_IDLE) || (cur == ST_WRITE)) && access_live(r.rs1_en, r.rs1);
        r2_ok = (cur != ST_READ2) && access_live(r.rs2_en, r.rs2);
        if (wr_ok)      return ST_WRITE;
        else if (r1_ok) return ST_READ1;
        else if (r2_ok) return ST_READ2;
        else            return ST_RESP;
    endfunction

    assign req_in = '{rs1: req_rs1, rs2: req_rs2, rd: req_rd,
                      rs1_en: req_rs1_en, rs2_en: req_rs2_en, wr_en: req_wr_en,
                      wdata: req_wdata};

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        req_ready_c  = 1'b0;
        rsp_valid_c  = 1'b0;
        rf_write_c   = 1'b0;
        rf_addr_c    = '0;
        rf_data_in_c = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                if (req_valid) begin
                    req_d   = req_in;
                    op1_d   = '0;
                    op2_d   = '0;
                    state_d = next_access(req_in, ST_IDLE);
                end
            end
            ST_WRITE: begin
                rf_addr_c    = req_q.rd;
                rf_data_in_c = req_q.wdata;
                rf_write_c   = 1'b1;
                state_d      = next_access(req_q, ST_WRITE);
            end
            ST_READ1: begin
                rf_addr_c = req_q.rs1;
                op1_d     = rf_data_out;
                state_d   = next_access(req_q, ST_READ1);
            end
            ST_READ2: begin
                rf_addr_c = req_q.rs2;
                op2_d     = rf_data_out;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_c = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating by reset keeps a coincident write cycle from reaching the bank.
    assign req_ready  = req_ready_c && !reset;
    assign rsp_valid  = rsp_valid_c && !reset;
    assign rf_write   = rf_write_c && !reset;
    assign rf_addr    = reset ? '0 : rf_addr_c;
    assign rf_data_in = reset ? '0 : rf_data_in_c;
    assign rsp_op1    = op1_q;
    assign rsp_op2    = op2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

endmodule
